// File: rtl/card_draw_arbiter_pkg.sv
// Shared card definitions for the blackjack datapath: the packed card format
// and the deck geometry constants used by the draw arbiter and decoder.
package card_draw_arbiter_pkg;

   localparam int DECK_CARDS = 52;
   localparam int SUIT_CARDS = 13;

   localparam logic [3:0] ACE = 4'd1;

   typedef struct packed {
      logic [1:0] suit;
      logic [3:0] rank;
   } card_t;

endpackage

// File: rtl/card_draw_arbiter_decode.sv
// Combinational decode of a deck position 0..51 into {suit, rank}, with
// suit = idx / 13 and rank = (idx % 13) + 1.
module card_index_decode
   import card_draw_arbiter_pkg::*;
(
   input  logic [5:0] idx,
   output card_t      card
);

   logic [1:0] suit;
   logic [5:0] base;
   logic [5:0] offset;

   // Compare against suit boundaries instead of dividing; only four suits exist.
   always_comb begin
      suit = 2'd0;
      base = 6'd0;
      if (idx >= 6'(3 * SUIT_CARDS)) begin
         suit = 2'd3;
         base = 6'(3 * SUIT_CARDS);
      end else if (idx >= 6'(2 * SUIT_CARDS)) begin
         suit = 2'd2;
         base = 6'(2 * SUIT_CARDS);
      end else if (idx >= 6'(SUIT_CARDS)) begin
         suit = 2'd1;
         base = 6'(SUIT_CARDS);
      end
      offset    = idx - base;
      card.suit = suit;
      card.rank = offset[3:0] + ACE;
   end

endmodule

// File: rtl/card_draw_arbiter.sv
// Shared card source: dealt-mask deck, free-running LFSR pick with linear
// probing, and round-robin arbitration between dealer and player draws.
module card_draw_arbiter
   import card_draw_arbiter_pkg::*;
#(
   parameter int          DECK_SIZE  = DECK_CARDS,
   parameter int          LOW_THRESH = 15,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dealer_req,
   input  logic       player_req,
   input  logic       shuffle_req,
   output logic [5:0] card,
   output logic       card_valid,
   output logic       grant_dealer,
   output logic       grant_player,
   output logic       busy,
   output logic [5:0] cards_left,
   output logic       deck_low
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHUFFLE,
      S_PICK,
      S_PROBE,
      S_DELIVER
   } arb_state_t;

   arb_state_t state;
   arb_state_t next_state;

   logic [15:0]          lfsr;
   logic [DECK_SIZE-1:0] mask;
   logic [5:0]           idx;
   logic [5:0]           pick_idx;
   logic [5:0]           count;
   logic                 dealer_pend;
   logic                 player_pend;
   logic                 shuffle_pend;
   logic                 last_player;
   logic                 win_player;
   logic                 pick_player;
   logic                 draw_pend;
   logic                 slot_taken;
   logic                 dealer_clr;
   logic                 player_clr;
   card_t                card_reg;
   card_t                decoded;

   assign draw_pend  = dealer_pend | player_pend;
   assign slot_taken = mask[idx];
   assign dealer_clr = (state == S_DELIVER) && !win_player;
   assign player_clr = (state == S_DELIVER) && win_player;

   // Player wins only when alone, or when both wait and the dealer was served last.
   assign pick_player = player_pend && (!dealer_pend || !last_player);

   // Fold the 6-bit random value into the deck range.
   assign pick_idx = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];

   card_index_decode u_decode (
      .idx  (idx),
      .card (decoded)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // An empty deck forces a shuffle before serving; the pending draw stays latched.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (shuffle_pend) begin
               next_state = S_SHUFFLE;
            end else if (draw_pend) begin
               next_state = (count == 6'd0) ? S_SHUFFLE : S_PICK;
            end
         end
         S_SHUFFLE: next_state = S_IDLE;
         S_PICK:    next_state = S_PROBE;
         S_PROBE: begin
            if (!slot_taken) begin
               next_state = S_DELIVER;
            end
         end
         S_DELIVER: next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_comb begin
      card_valid   = (state == S_DELIVER);
      grant_dealer = (state == S_DELIVER) && !win_player;
      grant_player = (state == S_DELIVER) && win_player;
      busy         = (state != S_IDLE);
   end

   assign card       = card_reg;
   assign cards_left = count;
   assign deck_low   = (count < 6'(LOW_THRESH));

   // Galois LFSR, polynomial 0xB400; runs every cycle so request timing adds entropy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
      end
   end

   // A repeat pulse on an already-set flag is dropped; clearing wins over capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dealer_pend  <= 1'b0;
         player_pend  <= 1'b0;
         shuffle_pend <= 1'b0;
      end else begin
         dealer_pend  <= dealer_clr ? 1'b0 : (dealer_pend | dealer_req);
         player_pend  <= player_clr ? 1'b0 : (player_pend | player_req);
         shuffle_pend <= (state == S_SHUFFLE) ? 1'b0 : (shuffle_pend | shuffle_req);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_player  <= 1'b0;
         last_player <= 1'b1;
      end else begin
         if (state == S_IDLE && next_state == S_PICK) begin
            win_player <= pick_player;
         end
         if (state == S_DELIVER) begin
            last_player <= win_player;
         end
      end
   end

   // Probe walks forward through the deck, wrapping from the last slot to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx <= 6'd0;
      end else if (state == S_PICK) begin
         idx <= pick_idx;
      end else if (state == S_PROBE && slot_taken) begin
         idx <= (idx == 6'(DECK_SIZE - 1)) ? 6'd0 : idx + 6'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask     <= '0;
         count    <= 6'(DECK_SIZE);
         card_reg <= '0;
      end else if (state == S_SHUFFLE) begin
         mask  <= '0;
         count <= 6'(DECK_SIZE);
      end else if (state == S_PROBE && !slot_taken) begin
         mask[idx] <= 1'b1;
         count     <= count - 6'd1;
         card_reg  <= decoded;
      end
   end

endmodule
